matrix_key_scanner: RTL
=======================

MATRIX_KEY_SCANNER -- requirements
Module: matrix_key_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, CLK cycles each column is driven during scan (legal >= 3).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 8, consecutive stable cycles required to accept a press or release (legal >= 2).
REQ-003 SHALL have port CLK  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  scan enable.
REQ-006 SHALL have port ROW  input  4  keypad rows, active-low, externally pulled up, asynchronous.
REQ-007 SHALL have port COL  output  4  keypad column drive, active-low.
REQ-008 SHALL have port KeyValue  output  4  hex code of last accepted key, held until next acceptance.
REQ-009 SHALL have port KeyPressFlag  output  1  one-cycle pulse per accepted press; feeds the key-value shift stage.
REQ-010 SHALL have port KeyDown  output  1  level, high from acceptance until release accepted.

Function
REQ-011 SHALL pass ROW through a 2-flop synchronizer; all decisions use the synchronized value (rs).
REQ-012 SHALL implement states IDLE, SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-013 IDLE: COL=4'b0000; any rs bit low -> SCAN with column index 0.
REQ-014 SCAN: COL drives only the current column low; rs sampled in last cycle of each SCAN_DIV window.
REQ-015 SCAN hit: lowest-index low row captured with current column -> DEBOUNCE; no hit -> next column; no hit on column 3 -> IDLE.
REQ-016 Key code SHALL be {row_idx[1:0], col_idx[1:0]} (row 0/col 0 = 0x0, row 3/col 3 = 0xF).
REQ-017 Multiple keys: first column in scan order wins; within a column, lowest row index wins.
REQ-018 DEBOUNCE: captured column held; counter increments each cycle captured rs bit is low; bit high before DEBOUNCE_CNT -> IDLE, no flag, KeyValue unchanged.
REQ-019 Counter reaching DEBOUNCE_CNT -> PRESSED; in the same transition KeyValue loads the code, KeyPressFlag=1 for exactly one cycle, KeyDown=1.
REQ-020 PRESSED: captured column held; captured rs bit high -> RELEASE; other keys ignored.
REQ-021 RELEASE: counter counts consecutive high cycles of captured bit; low resets counter, stays RELEASE; DEBOUNCE_CNT reached -> IDLE, KeyDown=0.
REQ-022 Exactly one KeyPressFlag pulse per press; holding a key never repeats the flag.
REQ-023 Counters SHALL saturate-free by construction (width clog2(max(SCAN_DIV,DEBOUNCE_CNT))+1), cleared on every state entry.
REQ-024 en=0: state forced to IDLE, counters cleared, COL=4'b0000, KeyPressFlag=0, KeyDown=0, KeyValue held; synchronizer keeps running.
REQ-025 en deasserted mid-DEBOUNCE or mid-PRESSED: no flag issued; re-enable restarts from IDLE.

Reset
REQ-026 nRST=0 at a CLK edge: state IDLE, COL=4'b0000, KeyValue=4'h0, KeyPressFlag=0, KeyDown=0, counters and synchronizer = cleared (synchronizer to 4'b1111).
REQ-027 Reset SHALL take priority over en; reset mid-press SHALL emit no flag.

Structure
REQ-028 Shared package SHALL hold state enum, default SCAN_DIV/DEBOUNCE_CNT constants, key code width (4).
REQ-029 One sub-module key_debounce_counter (clear, inc, terminal-count output) SHALL be used for DEBOUNCE and RELEASE.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-030 Key row 2/col 1 pressed clean for 100 cycles -> single KeyPressFlag pulse, KeyValue=0x9, KeyDown=1 until 8 stable high cycles after release.
REQ-031 Bounce: row toggles low 3 cycles/high 2 cycles four times then stable low -> exactly one flag, no flag during bounce.
REQ-032 Glitch: row low for 5 cycles only -> no flag, KeyValue unchanged, return to IDLE.
REQ-033 Keys 0x5 and 0xE held together -> KeyValue=0x5 (col 1 precedes col 2), one flag.
REQ-034 nRST=0 during DEBOUNCE -> outputs at reset values next cycle, no flag; en=0 during PRESSED -> KeyDown=0, KeyValue held.
REQ-035 Eight sequential presses 0x1..0x8 -> eight flags, KeyValue sequence matches, downstream shift stage shows 0x87654321.

Source files
------------

// File: rtl/matrix_key_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_key_scanner_pkg
// Description : Shared definitions for the 4x4 matrix key scanner: scanner
//               state encoding, default timing constants, key code width and
//               the row-priority helper used when a column hit is captured.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_key_scanner_pkg;

    localparam int c_SCAN_DIV_DEFAULT     = 4;
    localparam int c_DEBOUNCE_CNT_DEFAULT = 8;
    localparam int c_KEY_CODE_W           = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN     = 3'd1,
        DEBOUNCE = 3'd2,
        PRESSED  = 3'd3,
        RELEASE  = 3'd4
    } scanState_t;

    // Index of the lowest-numbered row that reads low (rows are active-low).
    // Returns 0 when no row is low; callers qualify with a separate hit test.
    function automatic logic [1:0] lowestLowRow(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_key_scanner_counter.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_counter
// Description : Clearable up-counter with a terminal-count flag. The flag is
//               high while the count equals TERM-1, so the cycle that would
//               bring the count to TERM is the one that completes the window.
// Ports       : CLK, nRST (sync, active-low), i_clear, i_inc -> o_termCount
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_counter #(
    parameter int WIDTH = 4,
    parameter int TERM  = 8
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_termCount
);

    localparam logic [WIDTH-1:0] c_TERM_M1 = WIDTH'(TERM - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (!nRST || i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_termCount = (r_count == c_TERM_M1);

endmodule
`default_nettype wire

// File: rtl/matrix_key_scanner.sv
`default_nettype none
// ============================================================================
// Module      : matrix_key_scanner
// Description : 4x4 keypad scanner with row synchronizer, column scan,
//               press/release debounce and a one-cycle accepted-press pulse.
// Ports       : CLK, nRST (sync, active-low), en (scan enable),
//               ROW[3:0] (active-low rows, async), COL[3:0] (active-low drive),
//               KeyValue[3:0] (last accepted code), KeyPressFlag (1-cycle
//               pulse per press), KeyDown (level until release accepted)
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_key_scanner
    import matrix_key_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = c_SCAN_DIV_DEFAULT,
    parameter int DEBOUNCE_CNT = c_DEBOUNCE_CNT_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    en,
    input  logic [3:0]              ROW,
    output logic [3:0]              COL,
    output logic [c_KEY_CODE_W-1:0] KeyValue,
    output logic                    KeyPressFlag,
    output logic                    KeyDown
);

    localparam int c_CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;

    scanState_t r_state, w_stateNext;
    logic [3:0] r_sync1, r_rs;
    logic [1:0] r_colIdx, w_colNext;
    logic [1:0] r_rowIdx, w_rowNext;
    logic [c_KEY_CODE_W-1:0] r_keyValue;
    logic r_keyPressFlag, r_keyDown;
    logic w_loadKey, w_clrDown;
    logic w_scanClr, w_scanInc, w_scanTc;
    logic w_dbClr, w_dbInc, w_dbTc;
    logic w_capBit;
    logic [3:0] w_col;

    // Two-flop synchronizer; idles at "no row pulled" and keeps running with en low.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_sync1 <= 4'b1111;
            r_rs    <= 4'b1111;
        end else begin
            r_sync1 <= ROW;
            r_rs    <= r_sync1;
        end
    end

    // Column dwell timer: terminal count marks the last cycle of a window,
    // by which time the synchronized rows reflect the driven column.
    key_debounce_counter #(
        .WIDTH (c_CNT_W),
        .TERM  (SCAN_DIV)
    ) u_scanDiv (
        .CLK         (CLK),
        .nRST        (nRST),
        .i_clear     (w_scanClr),
        .i_inc       (w_scanInc),
        .o_termCount (w_scanTc)
    );

    // Shared by DEBOUNCE (stable-low run) and RELEASE (stable-high run).
    key_debounce_counter #(
        .WIDTH (c_CNT_W),
        .TERM  (DEBOUNCE_CNT)
    ) u_debounce (
        .CLK         (CLK),
        .nRST        (nRST),
        .i_clear     (w_dbClr),
        .i_inc       (w_dbInc),
        .o_termCount (w_dbTc)
    );

    assign w_capBit = r_rs[r_rowIdx];

    always_comb begin
        w_stateNext = r_state;
        w_colNext   = r_colIdx;
        w_rowNext   = r_rowIdx;
        w_scanClr   = 1'b0;
        w_scanInc   = 1'b0;
        w_dbClr     = 1'b0;
        w_dbInc     = 1'b0;
        w_loadKey   = 1'b0;
        w_clrDown   = 1'b0;
        if (!en) begin
            w_stateNext = IDLE;
            w_scanClr   = 1'b1;
            w_dbClr     = 1'b1;
            w_clrDown   = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_scanClr = 1'b1;
                    w_dbClr   = 1'b1;
                    if (r_rs != 4'b1111) begin
                        w_stateNext = SCAN;
                        w_colNext   = 2'd0;
                    end
                end
                SCAN: begin
                    if (w_scanTc) begin
                        w_scanClr = 1'b1;
                        if (r_rs != 4'b1111) begin
                            w_rowNext   = lowestLowRow(r_rs);
                            w_stateNext = DEBOUNCE;
                            w_dbClr     = 1'b1;
                        end else if (r_colIdx == 2'd3) begin
                            w_stateNext = IDLE;
                        end else begin
                            w_colNext = r_colIdx + 2'd1;
                        end
                    end else begin
                        w_scanInc = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!w_capBit) begin
                        if (w_dbTc) begin
                            w_stateNext = PRESSED;
                            w_dbClr     = 1'b1;
                            w_loadKey   = 1'b1;
                        end else begin
                            w_dbInc = 1'b1;
                        end
                    end else begin
                        w_stateNext = IDLE;
                        w_dbClr     = 1'b1;
                    end
                end
                PRESSED: begin
                    if (w_capBit) begin
                        w_stateNext = RELEASE;
                        w_dbClr     = 1'b1;
                    end
                end
                RELEASE: begin
                    if (w_capBit) begin
                        if (w_dbTc) begin
                            w_stateNext = IDLE;
                            w_dbClr     = 1'b1;
                            w_clrDown   = 1'b1;
                        end else begin
                            w_dbInc = 1'b1;
                        end
                    end else begin
                        // Contact bounced back: the release run starts over.
                        w_dbClr = 1'b1;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_scanClr   = 1'b1;
                    w_dbClr     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state        <= IDLE;
            r_colIdx       <= 2'd0;
            r_rowIdx       <= 2'd0;
            r_keyValue     <= '0;
            r_keyPressFlag <= 1'b0;
            r_keyDown      <= 1'b0;
        end else begin
            r_state        <= w_stateNext;
            r_colIdx       <= w_colNext;
            r_rowIdx       <= w_rowNext;
            r_keyPressFlag <= w_loadKey;
            if (w_loadKey) begin
                r_keyValue <= {r_rowIdx, r_colIdx};
            end
            if (w_clrDown) begin
                r_keyDown <= 1'b0;
            end else if (w_loadKey) begin
                r_keyDown <= 1'b1;
            end
        end
    end

    // All columns low in IDLE so any key wakes the scanner; otherwise only
    // the scanned or captured column is driven.
    always_comb begin
        w_col = 4'b0000;
        if (r_state != IDLE) begin
            w_col = ~(4'b0001 << r_colIdx);
        end
    end

    assign COL          = w_col;
    assign KeyValue     = r_keyValue;
    assign KeyPressFlag = r_keyPressFlag;
    assign KeyDown      = r_keyDown;

endmodule
`default_nettype wire
